// File: rtl/avalon_mms_responder.sv
// Avalon-MM slave that mimics SDRAM timing: a 32-bit on-chip store read through a
// fixed-latency pipeline, with waitrequest stalls for power-up init and periodic refresh.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_INIT    | post-reset settle, waitrequest held high for P_INIT_CYCLES
// ST_READY   | commands accepted; refresh counter advancing
// ST_REFRESH | refresh stall, waitrequest high for P_REFRESH_CYCLES
module avalon_mms_responder #(
  parameter int P_MEM_AWIDTH     = 10,
  parameter int P_RD_LATENCY     = 3,
  parameter int P_MAX_PENDING    = 2,
  parameter int P_INIT_CYCLES    = 100,
  parameter int P_REFRESH_PERIOD = 780,
  parameter int P_REFRESH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] avalon_address,
  input  logic [3:0]  avalon_byteenable_n,
  input  logic        avalon_chipselect,
  input  logic [31:0] avalon_writedata,
  input  logic        avalon_read_n,
  input  logic        avalon_write_n,
  output logic [31:0] avalon_readdata,
  output logic        avalon_readdatavalid,
  output logic        avalon_waitrequest,
  output logic        init_done,
  output logic        err
);

  localparam int TMR_MAX   = (P_INIT_CYCLES > P_REFRESH_CYCLES) ? P_INIT_CYCLES : P_REFRESH_CYCLES;
  localparam int TW        = $clog2(TMR_MAX + 1);
  localparam int RW        = $clog2(P_REFRESH_PERIOD + 1);
  localparam int PW        = $clog2(P_MAX_PENDING + 2);
  localparam int MEM_DEPTH = 1 << P_MEM_AWIDTH;

  localparam logic [TW-1:0] INIT_LOAD = TW'(P_INIT_CYCLES - 1);
  localparam logic [TW-1:0] REF_LOAD  = TW'(P_REFRESH_CYCLES - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(P_REFRESH_PERIOD - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(P_MAX_PENDING);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_READY   = 2'd1,
    ST_REFRESH = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [RW-1:0]           rcnt_q, rcnt_d;
  logic [PW-1:0]           pend_q, pend_d;
  logic                    wait_q, wait_d;
  logic                    init_done_q;
  logic                    err_q;
  logic [P_RD_LATENCY-1:0] vld_q;
  logic [31:0]             data_q [P_RD_LATENCY];
  logic [31:0]             mem_q  [MEM_DEPTH];

  logic [P_MEM_AWIDTH-1:0] addr;
  logic                    cmd_acc;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    rd_done;
  logic                    unused_addr_hi;

  // upper address bits alias onto the store
  assign addr           = avalon_address[P_MEM_AWIDTH-1:0];
  assign unused_addr_hi = ^avalon_address[23:P_MEM_AWIDTH];

  assign cmd_acc = avalon_chipselect && !wait_q && (!avalon_read_n || !avalon_write_n);
  assign wr_acc  = cmd_acc && !avalon_write_n;
  assign rd_acc  = cmd_acc && !avalon_read_n && avalon_write_n;
  assign rd_done = vld_q[P_RD_LATENCY-1];

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (tmr_q == '0) state_d = ST_READY;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_READY: begin
        if (rcnt_q == REF_LAST) begin
          state_d = ST_REFRESH;
          rcnt_d  = '0;
          tmr_d   = REF_LOAD;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_REFRESH: begin
        if (tmr_q == '0) state_d = ST_READY;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
    pend_d = pend_q + PW'(rd_acc) - PW'(rd_done);
    // registered copy of the stall condition the next cycle will see
    wait_d = (state_d != ST_READY) || (rcnt_d == REF_LAST) || (pend_d == PEND_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      tmr_q       <= INIT_LOAD;
      rcnt_q      <= '0;
      pend_q      <= '0;
      wait_q      <= 1'b1;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      vld_q       <= '0;
      for (int k = 0; k < P_RD_LATENCY; k++) data_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      rcnt_q      <= rcnt_d;
      pend_q      <= pend_d;
      wait_q      <= wait_d;
      init_done_q <= init_done_q || (state_d == ST_READY);
      err_q       <= err_q || (cmd_acc && !avalon_read_n && !avalon_write_n);
      vld_q[0]    <= rd_acc;
      if (rd_acc) data_q[0] <= mem_q[addr];
      // data only advances with a valid token, so the last stage holds the last returned word
      for (int k = 1; k < P_RD_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

  // store survives reset
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (!avalon_byteenable_n[i]) mem_q[addr][8*i +: 8] <= avalon_writedata[8*i +: 8];
      end
    end
  end

  assign avalon_readdata      = data_q[P_RD_LATENCY-1];
  assign avalon_readdatavalid = rd_done;
  assign avalon_waitrequest   = wait_q;
  assign init_done            = init_done_q;
  assign err                  = err_q;

endmodule

// File: tb/tb_avalon_mms_responder.sv
// Directed bench for avalon_mms_responder: table of write/read vectors with hand-computed
// read data, plus sequences for init, pipelining, refresh, dual command and reset.
module tb_avalon_mms_responder;

  localparam int EXP_LAT  = 3;
  localparam int EXP_INIT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] avalon_address;
  logic [3:0]  avalon_byteenable_n;
  logic        avalon_chipselect;
  logic [31:0] avalon_writedata;
  logic        avalon_read_n;
  logic        avalon_write_n;
  logic [31:0] avalon_readdata;
  logic        avalon_readdatavalid;
  logic        avalon_waitrequest;
  logic        init_done;
  logic        err;

  avalon_mms_responder dut (
    .clk                  (clk),
    .rst                  (rst),
    .avalon_address       (avalon_address),
    .avalon_byteenable_n  (avalon_byteenable_n),
    .avalon_chipselect    (avalon_chipselect),
    .avalon_writedata     (avalon_writedata),
    .avalon_read_n        (avalon_read_n),
    .avalon_write_n       (avalon_write_n),
    .avalon_readdata      (avalon_readdata),
    .avalon_readdatavalid (avalon_readdatavalid),
    .avalon_waitrequest   (avalon_waitrequest),
    .init_done            (init_done),
    .err                  (err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  int          rq_cyc[$];
  logic [31:0] rq_data[$];
  always @(negedge clk) begin
    if (avalon_readdatavalid === 1'b1) begin
      rq_cyc.push_back(cyc);
      rq_data.push_back(avalon_readdata);
    end
  end

  typedef struct {
    bit          rd;
    bit          cs;
    logic [23:0] addr;
    logic [3:0]  be_n;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t w(input logic [23:0] a, input logic [3:0] be, input logic [31:0] d);
    vec_t v;
    v = '{1'b0, 1'b1, a, be, d, 32'h0};
    return v;
  endfunction

  function automatic vec_t wn(input logic [23:0] a, input logic [3:0] be, input logic [31:0] d);
    vec_t v;
    v = '{1'b0, 1'b0, a, be, d, 32'h0};
    return v;
  endfunction

  function automatic vec_t r(input logic [23:0] a, input logic [3:0] be, input logic [31:0] e);
    vec_t v;
    v = '{1'b1, 1'b1, a, be, 32'h0, e};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    avalon_chipselect   = 1'b0;
    avalon_read_n       = 1'b1;
    avalon_write_n      = 1'b1;
    avalon_address      = '0;
    avalon_byteenable_n = 4'hF;
    avalon_writedata    = '0;
  endtask

  // called just after a rising edge; returns just after a rising edge
  task automatic cmd(input bit rd, input bit wr, input bit cs, input logic [23:0] a,
                     input logic [3:0] be, input logic [31:0] d, output int acc);
    avalon_chipselect   = cs;
    avalon_read_n       = !rd;
    avalon_write_n      = !wr;
    avalon_address      = a;
    avalon_byteenable_n = be;
    avalon_writedata    = d;
    acc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!cs) break;
      if (!avalon_waitrequest) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    idle();
    if (cs && acc < 0) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout actual=never expected=accepted addr=0x%06h", a);
    end
  endtask

  task automatic wait_rdv(output int c, output logic [31:0] d, input string tag);
    c = -1;
    d = '0;
    for (int i = 0; i < 20 && rq_cyc.size() == 0; i++) begin
      @(negedge clk); #1;
    end
    if (rq_cyc.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_rdv_timeout actual=none expected=readdatavalid", tag);
    end else begin
      c = rq_cyc.pop_front();
      d = rq_data.pop_front();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [23:0] a, input logic [3:0] be, input logic [31:0] exp,
                         input string tag);
    int          acc;
    int          c;
    logic [31:0] d;
    cmd(1'b1, 1'b0, 1'b1, a, be, 32'h0, acc);
    wait_rdv(c, d, tag);
    if (acc >= 0 && c >= 0) begin
      chk({tag, "_lat"}, 32'(c - acc), 32'(EXP_LAT));
      chk({tag, "_data"}, d, exp);
    end
  endtask

  // asserts reset from the current cycle; returns just after the edge that ends cycle "-1"
  task automatic reset_seq(input string tag);
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_waitrequest"}, 32'(avalon_waitrequest), 32'd1);
    chk({tag, "_rdv"}, 32'(avalon_readdatavalid), 32'd0);
    chk({tag, "_readdata"}, avalon_readdata, 32'h0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_init(output int n, output logic done_before, output logic done_at);
    n = 0;
    done_before = 1'b0;
    done_at = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!avalon_waitrequest) begin
        done_at = init_done;
        break;
      end
      n++;
      done_before = init_done;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          c;
    int          n;
    int          hi;
    int          rd_acc_cyc;
    int          acc4[4];
    int          exp_gap[4];
    logic        db;
    logic        da;
    logic [31:0] d;
    logic [31:0] exp4[4];
    bit          pat[0:800];

    idle();
    vecs.push_back(w (24'h000010, 4'h0, 32'hDEADBEEF));
    vecs.push_back(w (24'h000010, 4'hD, 32'h00001200));
    vecs.push_back(r (24'h000010, 4'h0, 32'hDEAD12EF));
    vecs.push_back(w (24'h000020, 4'h0, 32'h11223344));
    vecs.push_back(w (24'h000020, 4'hE, 32'hAABBCCDD));
    vecs.push_back(r (24'h000020, 4'h0, 32'h112233DD));
    vecs.push_back(w (24'h000030, 4'h0, 32'hCAFEF00D));
    vecs.push_back(w (24'h000430, 4'h6, 32'h12345678));
    vecs.push_back(r (24'hFFF030, 4'h0, 32'h12FEF078));
    vecs.push_back(w (24'h0003FF, 4'h0, 32'h0F0F0F0F));
    vecs.push_back(r (24'h0007FF, 4'h0, 32'h0F0F0F0F));
    vecs.push_back(w (24'h0003FF, 4'hF, 32'hFFFFFFFF));
    vecs.push_back(r (24'h0003FF, 4'h0, 32'h0F0F0F0F));
    vecs.push_back(w (24'h000001, 4'h0, 32'hA0000001));
    vecs.push_back(w (24'h000002, 4'h0, 32'hB0000002));
    vecs.push_back(w (24'h000003, 4'h0, 32'hC0000003));
    vecs.push_back(w (24'h000004, 4'h0, 32'hD0000004));
    vecs.push_back(wn(24'h000010, 4'h0, 32'h00000000));
    vecs.push_back(r (24'h000010, 4'hF, 32'hDEAD12EF));

    reset_seq("rst0");

    // read held from the first cycle after reset release
    avalon_chipselect = 1'b1;
    avalon_read_n     = 1'b0;
    avalon_address    = 24'h000040;
    wait_init(n, db, da);
    acc = cyc;
    @(posedge clk); #1;
    idle();
    chk("init_wait_cycles", 32'(n), 32'(EXP_INIT));
    chk("init_done_before", 32'(db), 32'd0);
    chk("init_done_rise", 32'(da), 32'd1);
    wait_rdv(c, d, "init_rd");
    chk("init_rd_lat", 32'(c - acc), 32'(EXP_LAT));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rd) do_read(vecs[i].addr, vecs[i].be_n, vecs[i].exp, $sformatf("vec%0d", i));
      else            cmd(1'b0, 1'b1, vecs[i].cs, vecs[i].addr, vecs[i].be_n, vecs[i].wdata, acc);
    end

    repeat (3) @(negedge clk);
    chk("hold_rdv_low", 32'(avalon_readdatavalid), 32'd0);
    chk("hold_data", avalon_readdata, 32'hDEAD12EF);
    @(posedge clk); #1;

    // reads to 1..4 held continuously against the two-outstanding limit
    exp_gap = '{0, 1, 4, 5};
    exp4    = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
    acc4    = '{0, 0, 0, 0};
    avalon_chipselect   = 1'b1;
    avalon_read_n       = 1'b0;
    avalon_byteenable_n = 4'hF;
    avalon_address      = 24'h000001;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (!avalon_waitrequest) begin
        acc4[n] = cyc;
        n++;
      end
      @(posedge clk); #1;
      if (n < 4) avalon_address = 24'(n + 1);
    end
    idle();
    chk("pipe_accepts", 32'(n), 32'd4);
    for (int i = 1; i < 4; i++) chk($sformatf("pipe_gap%0d", i), 32'(acc4[i] - acc4[0]), 32'(exp_gap[i]));
    for (int i = 0; i < 4; i++) begin
      wait_rdv(c, d, $sformatf("pipe%0d", i));
      chk($sformatf("pipe%0d_lat", i), 32'(c - acc4[i]), 32'(EXP_LAT));
      chk($sformatf("pipe%0d_data", i), d, exp4[i]);
    end

    chk("err_clear", 32'(err), 32'd0);
    cmd(1'b1, 1'b1, 1'b1, 24'h000400, 4'h0, 32'h5A5A5A5A, acc);
    repeat (6) @(negedge clk);
    chk("dual_err", 32'(err), 32'd1);
    chk("dual_no_rdv", 32'(rq_cyc.size()), 32'd0);
    @(posedge clk); #1;
    do_read(24'h000000, 4'h0, 32'h5A5A5A5A, "alias_rd");
    chk("err_sticky", 32'(err), 32'd1);

    // reset one cycle after a read is accepted
    cmd(1'b1, 1'b0, 1'b1, 24'h000010, 4'h0, 32'h0, acc);
    reset_seq("rst1");
    wait_init(n, db, da);
    chk("reinit_wait_cycles", 32'(n), 32'(EXP_INIT));
    chk("rst_flush_no_rdv", 32'(rq_cyc.size()), 32'd0);

    // continuous traffic from READY cycle 2; read of 0x10 in READY cycle 779
    pat[0] = 1'b0;
    pat[1] = 1'b0;
    rd_acc_cyc = -1;
    for (int k = 2; k <= 800; k++) begin
      @(posedge clk); #1;
      avalon_chipselect = 1'b1;
      if (k == 779) begin
        avalon_read_n       = 1'b0;
        avalon_write_n      = 1'b1;
        avalon_address      = 24'h000010;
        avalon_byteenable_n = 4'hF;
      end else begin
        avalon_read_n       = 1'b1;
        avalon_write_n      = 1'b0;
        avalon_address      = 24'h000100 + 24'(k % 16);
        avalon_byteenable_n = 4'h0;
        avalon_writedata    = 32'(k);
      end
      @(negedge clk);
      pat[k] = avalon_waitrequest;
      if (k == 779 && !avalon_waitrequest) rd_acc_cyc = cyc;
    end
    @(posedge clk); #1;
    idle();
    hi = 0;
    for (int k = 1; k <= 800; k++) hi += int'(pat[k]);
    chk("ref_wait_779", 32'(pat[779]), 32'd0);
    chk("ref_wait_780", 32'(pat[780]), 32'd1);
    chk("ref_wait_788", 32'(pat[788]), 32'd1);
    chk("ref_wait_789", 32'(pat[789]), 32'd0);
    chk("ref_wait_total", 32'(hi), 32'd9);
    wait_rdv(c, d, "ref_rd");
    chk("ref_rd_lat", 32'(c - rd_acc_cyc), 32'(EXP_LAT));
    chk("ref_rd_data", d, 32'hDEAD12EF);

    do_read(24'h000000, 4'h0, 32'h5A5A5A5A, "post_rst_rd");
    chk("post_rst_init_done", 32'(init_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
